// File: rtl/pbit_pkg.sv
// Shared constants and helpers for the p-bit array: LFSR shape, seed mixing,
// field saturation and spin decoding.
package pbit_pkg;

    localparam int unsigned       LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED_MIX  = 16'h1F35;

    // Clamp a signed value into the range of a width-bit two's complement number.
    function automatic int saturate(input int val, input int unsigned width);
        int hi;
        int lo;
        hi = (1 <<< (width - 1)) - 1;
        lo = -(1 <<< (width - 1));
        if (val > hi) return hi;
        if (val < lo) return lo;
        return val;
    endfunction

    function automatic int spin(input logic b);
        return b ? 1 : -1;
    endfunction

endpackage

// File: rtl/pbit_lfsr.sv
// 16-bit Galois LFSR supplying one p-bit's random threshold; free-running after reset.
module pbit_lfsr
    import pbit_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] state
);

    // An all-zero state would lock up the LFSR.
    localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? 16'h0001 : SEED;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/pbit_array_core.sv
// Bank of probabilistic bits with per-bit LFSR thresholds and sweep-complete sampling.
// Optional sweep counter output enabled by defining PBIT_SWEEP_CNT_EN.
module pbit_array_core
    import pbit_pkg::*;
#(
    parameter int unsigned N_PBITS    = 5,
    parameter int unsigned W          = 8,
    parameter int unsigned RW         = 8,
    parameter int unsigned BETA_SHIFT = 0,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_PBITS-1:0]             update_in,
    input  logic [N_PBITS*N_PBITS*W-1:0]   j_flat,
    input  logic [N_PBITS*W-1:0]           h_flat,
    input  logic [N_PBITS-1:0]             clamp_en,
    input  logic [N_PBITS-1:0]             clamp_val,
    output logic [N_PBITS-1:0]             m_out,
    output logic                           sample_valid,
    output logic [N_PBITS-1:0]             m_sample
`ifdef PBIT_SWEEP_CNT_EN
    ,
    output logic [15:0]                    sweep_cnt
`endif
);

    localparam int unsigned ACC_W = W + $clog2(N_PBITS) + 1;
    localparam logic signed [RW-1:0] SAT_MAX = {1'b0, {(RW - 1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {1'b1, {(RW - 1){1'b0}}};

    logic [LFSR_W-1:0]       lfsr_state [N_PBITS];
    logic signed [ACC_W-1:0] acc        [N_PBITS];
    logic signed [RW-1:0]    sat_field  [N_PBITS];
    logic [N_PBITS-1:0]      decision;
    logic [N_PBITS-1:0]      m_next;
    logic [N_PBITS-1:0]      mask;
    logic [N_PBITS-1:0]      mask_next;
    logic                    unused_bits;

    for (genvar i = 0; i < N_PBITS; i++) begin : g_lfsr
        pbit_lfsr #(
            .SEED(SEED ^ LFSR_W'(i * SEED_MIX))
        ) u_lfsr (
            .clk  (clk),
            .reset(reset),
            .state(lfsr_state[i])
        );
    end

    // Fields read registered m_out only, so parallel updates see pre-edge states.
    always_comb begin
        acc       = '{default: '0};
        sat_field = '{default: '0};
        decision  = '0;
        m_next    = m_out;
        for (int i = 0; i < N_PBITS; i++) begin
            acc[i] = ACC_W'($signed(h_flat[i*W +: W]));
            for (int j = 0; j < N_PBITS; j++) begin
                if (j != i) begin
                    acc[i] = acc[i] + ACC_W'($signed(j_flat[(i*N_PBITS+j)*W +: W]))
                                    * ACC_W'(spin(m_out[j]));
                end
            end
            sat_field[i] = RW'(saturate(int'(acc[i]) <<< BETA_SHIFT, RW));
            if (sat_field[i] == SAT_MAX) begin
                decision[i] = 1'b1;
            end else if (sat_field[i] == SAT_MIN) begin
                decision[i] = 1'b0;
            end else begin
                decision[i] = sat_field[i] > $signed(lfsr_state[i][RW-1:0]);
            end
            if (clamp_en[i]) begin
                m_next[i] = clamp_val[i];
            end else if (update_in[i]) begin
                m_next[i] = decision[i];
            end
        end
    end

    assign mask_next = mask | update_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_out        <= '0;
            mask         <= '0;
            sample_valid <= 1'b0;
            m_sample     <= '0;
        end else begin
            m_out <= m_next;
            if (&mask_next) begin
                sample_valid <= 1'b1;
                m_sample     <= m_next;
                mask         <= '0;
            end else begin
                sample_valid <= 1'b0;
                mask         <= mask_next;
            end
        end
    end

`ifdef PBIT_SWEEP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_cnt <= '0;
        end else if (&mask_next && sweep_cnt != 16'hFFFF) begin
            sweep_cnt <= sweep_cnt + 16'd1;
        end
    end
`endif

    // Diagonal couplings and upper LFSR bits are intentionally ignored.
    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < N_PBITS; i++) begin
            unused_bits = unused_bits ^ (^j_flat[(i*N_PBITS+i)*W +: W])
                                      ^ (^lfsr_state[i][LFSR_W-1:RW]);
        end
    end

endmodule

// File: tb/tb_pbit_array_core.sv
// Self-checking bench for pbit_array_core: directed vector table, corner sequences,
// and randomized stimulus against an arithmetic reference model.
module tb_pbit_array_core;

    localparam int N    = 5;
    localparam int BETA = 0;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic [N-1:0]     update_in = '0;
    logic [N-1:0]     clamp_en  = '0;
    logic [N-1:0]     clamp_val = '0;
    logic [N*N*8-1:0] j_flat    = '0;
    logic [N*8-1:0]   h_flat    = '0;
    logic [N-1:0]     m_out;
    logic             sample_valid;
    logic [N-1:0]     m_sample;
`ifdef PBIT_SWEEP_CNT_EN
    logic [15:0]      sweep_cnt;
`endif

    pbit_array_core #(
        .N_PBITS   (N),
        .W         (8),
        .RW        (8),
        .BETA_SHIFT(BETA),
        .SEED      (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .update_in   (update_in),
        .j_flat      (j_flat),
        .h_flat      (h_flat),
        .clamp_en    (clamp_en),
        .clamp_val   (clamp_val),
        .m_out       (m_out),
        .sample_valid(sample_valid),
`ifdef PBIT_SWEEP_CNT_EN
        .sweep_cnt   (sweep_cnt),
`endif
        .m_sample    (m_sample)
    );

    always #5 clk = ~clk;

    // Reference model state
    int           h  [N];
    int           jm [N][N];
    int           lfsr [N];
    logic [N-1:0] exp_m;
    logic [N-1:0] exp_samp;
    logic [N-1:0] exp_mask;
    logic         exp_sv;
    int           exp_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int           hv;
        logic [N-1:0] upd;
        logic [N-1:0] m;
        logic         sv;
        logic [N-1:0] samp;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seed_of(input int i);
        int s;
        s = (16'hACE1 ^ (i * 16'h1F35)) & 16'hFFFF;
        return (s == 0) ? 1 : s;
    endfunction

    task automatic clear_weights();
        for (int i = 0; i < N; i++) begin
            h[i] = 0;
            for (int j = 0; j < N; j++) jm[i][j] = 0;
        end
    endtask

    task automatic pack_weights();
        for (int i = 0; i < N; i++) begin
            h_flat[i*8 +: 8] = 8'(h[i]);
            for (int j = 0; j < N; j++) j_flat[(i*N+j)*8 +: 8] = 8'(jm[i][j]);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        update_in = '0;
        repeat (cycles) @(posedge clk);
        exp_m    = '0;
        exp_samp = '0;
        exp_mask = '0;
        exp_sv   = 1'b0;
        exp_cnt  = 0;
        for (int i = 0; i < N; i++) lfsr[i] = seed_of(i);
        #1;
        reset = 1'b0;
    endtask

    // Apply one cycle of stimulus; the model predicts the post-edge outputs.
    task automatic step(input logic [N-1:0] upd);
        logic [N-1:0] nm;
        int f;
        int r;
        update_in = upd;
        pack_weights();
        nm = exp_m;
        for (int i = 0; i < N; i++) begin
            f = h[i];
            for (int j = 0; j < N; j++) begin
                if (j != i) f += jm[i][j] * (exp_m[j] ? 1 : -1);
            end
            f = f * (1 << BETA);
            if (f > 127) f = 127;
            if (f < -128) f = -128;
            r = lfsr[i] & 'hFF;
            if (r >= 128) r -= 256;
            if (clamp_en[i]) nm[i] = clamp_val[i];
            else if (upd[i]) nm[i] = (f == 127) ? 1'b1 : (f == -128) ? 1'b0 : (f > r);
        end
        exp_m = nm;
        if ((exp_mask | upd) == '1) begin
            exp_sv   = 1'b1;
            exp_samp = nm;
            exp_mask = '0;
            if (exp_cnt < 65535) exp_cnt++;
        end else begin
            exp_sv   = 1'b0;
            exp_mask = exp_mask | upd;
        end
        for (int i = 0; i < N; i++) lfsr[i] = (lfsr[i] >> 1) ^ ((lfsr[i] & 1) != 0 ? 'hB400 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_m_out"}, m_out, exp_m);
        chk({tag, "_sample_valid"}, sample_valid, exp_sv);
        chk({tag, "_m_sample"}, m_sample, exp_samp);
`ifdef PBIT_SWEEP_CNT_EN
        chk({tag, "_sweep_cnt"}, sweep_cnt, exp_cnt);
`endif
    endtask

    initial begin
        int pulses;

        tbl[0]  = '{127,  5'b00001, 5'b00001, 1'b0, 5'b00000};
        tbl[1]  = '{127,  5'b00010, 5'b00011, 1'b0, 5'b00000};
        tbl[2]  = '{127,  5'b00100, 5'b00111, 1'b0, 5'b00000};
        tbl[3]  = '{127,  5'b01000, 5'b01111, 1'b0, 5'b00000};
        tbl[4]  = '{127,  5'b10000, 5'b11111, 1'b1, 5'b11111};
        tbl[5]  = '{127,  5'b00000, 5'b11111, 1'b0, 5'b11111};
        tbl[6]  = '{-128, 5'b11111, 5'b00000, 1'b1, 5'b00000};
        tbl[7]  = '{-128, 5'b11111, 5'b00000, 1'b1, 5'b00000};
        tbl[8]  = '{127,  5'b00011, 5'b00011, 1'b0, 5'b00000};
        tbl[9]  = '{127,  5'b11100, 5'b11111, 1'b1, 5'b11111};
        tbl[10] = '{-128, 5'b00001, 5'b11110, 1'b0, 5'b11111};

        clear_weights();
        pack_weights();
        do_reset(3);
        chk("reset_m_out", m_out, 0);
        chk("reset_sample_valid", sample_valid, 0);
        chk("reset_m_sample", m_sample, 0);
`ifdef PBIT_SWEEP_CNT_EN
        chk("reset_sweep_cnt", sweep_cnt, 0);
`endif

        // Directed table with saturated fields (outcome independent of LFSRs)
        for (int k = 0; k < 11; k++) begin
            for (int i = 0; i < N; i++) h[i] = tbl[k].hv;
            step(tbl[k].upd);
            chk("tbl_m_out", m_out, tbl[k].m);
            chk("tbl_sample_valid", sample_valid, tbl[k].sv);
            chk("tbl_m_sample", m_sample, tbl[k].samp);
        end

        // Parallel mode: a sample every cycle
        clear_weights();
        do_reset(2);
        pulses = 0;
        repeat (4) begin
            step('1);
            check_model("par");
            if (sample_valid === 1'b1) pulses++;
        end
        chk("par_pulse_count", pulses, 4);
        step('0);
        chk("par_idle_sv", sample_valid, 0);

        // Clamp forcing through a strong coupling
        clear_weights();
        jm[0][1] = 127;
        jm[1][0] = 127;
        clamp_en  = 5'b00001;
        clamp_val = 5'b00001;
        do_reset(2);
        step(5'b00001);
        chk("clamp_m0_hi", m_out[0], 1);
        step(5'b00010);
        chk("clamp_m1_hi", m_out[1], 1);
        step(5'b00010);
        chk("clamp_m1_hi_again", m_out[1], 1);
        clamp_val = 5'b00000;
        step(5'b00000);
        chk("clamp_m0_lo", m_out[0], 0);
        step(5'b00010);
        check_model("clamp_follow");
        chk("clamp_no_sample", sample_valid, 0);
        clamp_en = '0;

        // Reset mid-sweep discards the partial mask
        clear_weights();
        for (int i = 0; i < N; i++) h[i] = 127;
        do_reset(2);
        step(5'b00001);
        step(5'b00010);
        step(5'b00100);
        do_reset(2);
        chk("midrst_m_out", m_out, 0);
        chk("midrst_m_sample", m_sample, 0);
        pulses = 0;
        for (int i = 0; i < N; i++) begin
            step(N'(1 << i));
            if (sample_valid === 1'b1) pulses++;
        end
        chk("midrst_last_sv", sample_valid, 1);
        chk("midrst_pulse_count", pulses, 1);
        chk("midrst_m_sample_full", m_sample, 5'b11111);
`ifdef PBIT_SWEEP_CNT_EN
        chk("midrst_sweep_cnt", sweep_cnt, 1);
`endif

        // Randomized stimulus against the model
        do_reset(2);
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) begin
                for (int i = 0; i < N; i++) begin
                    h[i] = int'($urandom_range(80)) - 40;
                    for (int j = 0; j < N; j++) jm[i][j] = int'($urandom_range(80)) - 40;
                end
                if ($urandom_range(3) == 0) jm[1][2] = 127;
                clamp_en  = ($urandom_range(3) == 0) ? N'($urandom_range(31)) : '0;
                clamp_val = N'($urandom_range(31));
            end
            case ($urandom_range(3))
                0:       step('1);
                1:       step('0);
                default: step(N'($urandom_range(31)));
            endcase
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
